min_max_scanner: RTL and testbench

- Parametrised successor to the four-entry push-button smallest-value display.
- Holds N user-loaded W-bit values. Each value is written from a shared data bus by a per-channel load strobe.
- A sequential scan FSM finds the minimum or maximum value and its channel index.
- Drives the LCD top level with the stored values, the result, the result index and a hex ASCII character of the result.

---
 rtl/min_max_scanner_if.sv | 41 ++++
 rtl/min_max_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_min_max_scanner.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/min_max_scanner_if.sv
// min_max_scanner_if
//   Bundles the load/data inputs and result outputs of min_max_scanner.
//   Parameters N (channels), W (value width), IW (index width) must match
//   the scanner instance that uses this interface.
//   Signals:
//     load         N     raw per-channel load strobes (level, async to clk)
//     holder       W     shared data bus written on a load event
//     mode         1     0 = find minimum, 1 = find maximum
//     values       N*W   stored values, channel k at [k*W +: W]
//     result       W     winning value of the last completed scan
//     result_index IW    channel index of result
//     result_char  8     ASCII hex of result[3:0]
//     valid        1     result outputs match current values and mode
//     busy         1     scan in progress
//   modport master: the side driving loads (bench / button logic)
//   modport slave : the scanner itself
interface min_max_scanner_if #(
   parameter int N  = 4,
   parameter int W  = 4,
   parameter int IW = $clog2(N)
);
   logic [N-1:0]   load;
   logic [W-1:0]   holder;
   logic           mode;
   logic [N*W-1:0] values;
   logic [W-1:0]   result;
   logic [IW-1:0]  result_index;
   logic [7:0]     result_char;
   logic           valid;
   logic           busy;

   modport master (
      output load, holder, mode,
      input  values, result, result_index, result_char, valid, busy
   );

   modport slave (
      input  load, holder, mode,
      output values, result, result_index, result_char, valid, busy
   );
endinterface

// File: rtl/min_max_scanner.sv
// min_max_scanner
//   Holds N W-bit values loaded from a shared bus by per-channel strobes and
//   runs a one-channel-per-cycle scan to find the minimum (mode 0) or the
//   maximum (mode 1) value and its index. Any load or change of mode restarts
//   the scan; valid marks a result that matches the current contents.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    min_max_scanner_if.slave (load, holder, mode in; values,
//            result, result_index, result_char, valid, busy out)
module min_max_scanner #(
   parameter int N  = 4,
   parameter int W  = 4,
   parameter int IW = $clog2(N)
) (
   input logic               clk,
   input logic               reset,
   min_max_scanner_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t         state;
   state_t         state_next;

   logic [N-1:0]   load_s1;
   logic [N-1:0]   load_s2;
   logic [N-1:0]   load_s3;
   logic [N-1:0]   load_pulse;
   logic           mode_r;
   logic           mode_prev;
   logic           trigger;

   logic [N*W-1:0] values_q;
   logic [W-1:0]   value_arr [N];

   logic [IW-1:0]  scan_idx;
   logic [IW-1:0]  scan_idx_next;
   logic [W-1:0]   candidate;
   logic [W-1:0]   cand_next;
   logic [IW-1:0]  cand_idx;
   logic [IW-1:0]  cand_idx_next;
   logic [W-1:0]   scan_val;
   logic           take;

   logic [W-1:0]   result_q;
   logic [IW-1:0]  result_idx_q;
   logic [7:0]     result_char_q;
   logic           valid_q;
   logic           valid_next;
   logic           result_load;
   logic [3:0]     cand_nibble;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) begin
         return 8'h30 + {4'h0, n};
      end
      return 8'h37 + {4'h0, n};
   endfunction

   // Narrow values are zero-extended so the ASCII digit is still defined.
   if (W >= 4) begin : g_nib_wide
      assign cand_nibble = cand_next[3:0];
   end else begin : g_nib_narrow
      assign cand_nibble = {{(4 - W){1'b0}}, cand_next};
   end

   // The mode is registered once and compared with its previous registered
   // value, so a change retriggers exactly one scan.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_s1   <= '0;
         load_s2   <= '0;
         load_s3   <= '0;
         mode_r    <= 1'b0;
         mode_prev <= 1'b0;
      end else begin
         load_s1   <= bus.load;
         load_s2   <= load_s1;
         load_s3   <= load_s2;
         mode_r    <= bus.mode;
         mode_prev <= mode_r;
      end
   end

   assign load_pulse = load_s2 & ~load_s3;
   assign trigger    = (|load_pulse) | (mode_r ^ mode_prev);

   // Storage is written independently of the scan state; several
   // simultaneous pulses all take the same holder value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         values_q <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (load_pulse[k]) begin
               values_q[k*W +: W] <= bus.holder;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         value_arr[k] = values_q[k*W +: W];
      end
   end

   assign scan_val = value_arr[scan_idx];
   // Strict compare keeps the lower index on ties.
   assign take     = mode_r ? (scan_val > candidate) : (scan_val < candidate);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A trigger in any state restarts the scan at channel 0; DONE only
   // publishes the candidate when no trigger arrives in that same cycle.
   always_comb begin
      state_next    = state;
      scan_idx_next = scan_idx;
      cand_next     = candidate;
      cand_idx_next = cand_idx;
      valid_next    = valid_q;
      result_load   = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_next    = SCAN;
               scan_idx_next = '0;
               valid_next    = 1'b0;
            end
         end
         SCAN: begin
            if (trigger) begin
               scan_idx_next = '0;
               valid_next    = 1'b0;
            end else begin
               if (scan_idx == '0 || take) begin
                  cand_next     = scan_val;
                  cand_idx_next = scan_idx;
               end
               if (scan_idx == IW'(N - 1)) begin
                  state_next = DONE;
               end else begin
                  scan_idx_next = scan_idx + 1'b1;
               end
            end
         end
         DONE: begin
            if (trigger) begin
               state_next    = SCAN;
               scan_idx_next = '0;
               valid_next    = 1'b0;
            end else begin
               state_next  = IDLE;
               valid_next  = 1'b1;
               result_load = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_idx      <= '0;
         candidate     <= '0;
         cand_idx      <= '0;
         valid_q       <= 1'b0;
         result_q      <= '0;
         result_idx_q  <= '0;
         result_char_q <= 8'h30;
      end else begin
         scan_idx  <= scan_idx_next;
         candidate <= cand_next;
         cand_idx  <= cand_idx_next;
         valid_q   <= valid_next;
         if (result_load) begin
            result_q      <= cand_next;
            result_idx_q  <= cand_idx_next;
            result_char_q <= hex_ascii(cand_nibble);
         end
      end
   end

   assign bus.values       = values_q;
   assign bus.result       = result_q;
   assign bus.result_index = result_idx_q;
   assign bus.result_char  = result_char_q;
   assign bus.valid        = valid_q;
   assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_min_max_scanner.sv
// tb_min_max_scanner
//   Self-checking bench for min_max_scanner. A behavioural model tracks the
//   sampled inputs, the stored values and the time of the latest trigger;
//   a compare process checks every output on every falling edge. Directed
//   scenarios add literal expectations, then a randomized phase follows.
//   A second instance (N = 8, W = 8) checks the wide configuration.
module tb_min_max_scanner;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int IW  = 2;
   localparam int N8  = 8;
   localparam int W8  = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   min_max_scanner_if #(.N(N), .W(W)) bus ();
   min_max_scanner_if #(.N(N8), .W(W8)) bus8 ();

   min_max_scanner #(.N(N), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   min_max_scanner #(.N(N8), .W(W8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   int assert_count = 0;
   int fail_count   = 0;

   // Behavioural model state.
   logic [W-1:0]  m_vals [N];
   logic [N-1:0]  hist_l1 = '0;
   logic [N-1:0]  hist_l2 = '0;
   logic [N-1:0]  hist_l3 = '0;
   logic          hist_m1 = 1'b0;
   logic          hist_m2 = 1'b0;
   bit            m_pending = 1'b0;
   bit            m_valid = 1'b0;
   int            m_cyc = 0;
   int            m_last_trig = 0;
   logic [W-1:0]  m_res = '0;
   logic [IW-1:0] m_idx = '0;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] hex_of(input logic [7:0] v);
      string digits;
      digits = "0123456789ABCDEF";
      return digits[v[3:0]];
   endfunction

   // Winner by the stated rule: strict unsigned compare, lowest index on tie.
   task automatic model_pick(input logic use_max);
      int best;
      best = 0;
      for (int k = 1; k < N; k++) begin
         if (use_max ? (m_vals[k] > m_vals[best]) : (m_vals[k] < m_vals[best])) begin
            best = k;
         end
      end
      m_res = m_vals[best];
      m_idx = IW'(best);
   endtask

   // A raw rise seen at edge e is written at edge e+2 (sample history);
   // a mode change seen at edge e retriggers at edge e+1. A scan started at
   // edge E publishes at edge E+N+1 unless retriggered first.
   task automatic model_step();
      logic [N-1:0] pulses;
      bit           chg;
      if (reset) begin
         foreach (m_vals[k]) m_vals[k] = '0;
         hist_l1 = '0; hist_l2 = '0; hist_l3 = '0;
         hist_m1 = 1'b0; hist_m2 = 1'b0;
         m_pending = 1'b0; m_valid = 1'b0;
         m_res = '0; m_idx = '0; m_cyc = 0; m_last_trig = 0;
      end else begin
         m_cyc++;
         pulses = hist_l2 & ~hist_l3;
         chg    = (hist_m1 != hist_m2);
         for (int k = 0; k < N; k++) begin
            if (pulses[k]) m_vals[k] = bus.holder;
         end
         if (pulses != '0 || chg) begin
            m_pending   = 1'b1;
            m_valid     = 1'b0;
            m_last_trig = m_cyc;
         end else if (m_pending && m_cyc == m_last_trig + N + 1) begin
            m_pending = 1'b0;
            m_valid   = 1'b1;
            model_pick(hist_m1);
         end
         hist_l3 = hist_l2; hist_l2 = hist_l1; hist_l1 = bus.load;
         hist_m2 = hist_m1; hist_m1 = bus.mode;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         model_step();
      end
   end

   task automatic compare_step();
      logic [N*W-1:0] exp_vals;
      for (int k = 0; k < N; k++) exp_vals[k*W +: W] = m_vals[k];
      check_output("values", bus.values, exp_vals);
      check_output("valid", bus.valid, m_valid);
      check_output("busy", bus.busy, m_pending);
      check_output("result", bus.result, m_res);
      check_output("result_index", bus.result_index, m_idx);
      check_output("result_char", bus.result_char, hex_of({4'h0, m_res}));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         compare_step();
      end
   end

   task automatic apply_stimulus(input logic [N-1:0] mask, input logic [W-1:0] val,
                                 input int hold);
      @(negedge clk);
      bus.holder = val;
      bus.load   = mask;
      repeat (hold) @(negedge clk);
      bus.load = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(bus.valid === 1'b1 && bus.busy === 1'b0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         assert_count++;
         fail_count++;
         $display("[TB] FAIL %s: timeout, valid=%0b busy=%0b, required valid=1 busy=0",
                  name, bus.valid, bus.busy);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin : main
      logic [W8-1:0]    vals8 [N8];
      logic [N8*W8-1:0] exp8;
      int               best8;
      int               starts;
      int               busy_seen;
      int               n;
      logic             prev_busy;
      bit               busy_dropped;

      bus.load = '0; bus.holder = '0; bus.mode = 1'b0;
      bus8.load = '0; bus8.holder = '0; bus8.mode = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      check_output("rst_values", bus.values, 16'h0000);
      check_output("rst_result", bus.result, 0);
      check_output("rst_index", bus.result_index, 0);
      check_output("rst_char", bus.result_char, 8'h30);
      check_output("rst_valid", bus.valid, 0);
      check_output("rst_busy", bus.busy, 0);

      $display("[TB] load 7,3,9,5 in minimum mode");
      apply_stimulus(4'b0001, 4'd7, 4); wait_idle("load_ch0");
      apply_stimulus(4'b0010, 4'd3, 4); wait_idle("load_ch1");
      apply_stimulus(4'b0100, 4'd9, 4); wait_idle("load_ch2");
      @(negedge clk);
      bus.holder = 4'd5;
      bus.load   = 4'b1000;
      repeat (4) @(negedge clk);
      bus.load = '0;
      repeat (3) @(negedge clk);
      check_output("latency_valid_low", bus.valid, 0);
      check_output("latency_busy_high", bus.busy, 1);
      @(negedge clk);
      check_output("latency_valid_high", bus.valid, 1);
      check_output("min_values", bus.values, 16'h5937);
      check_output("min_result", bus.result, 4'd3);
      check_output("min_index", bus.result_index, 2'd1);
      check_output("min_char", bus.result_char, 8'h33);

      $display("[TB] switch to maximum mode");
      @(negedge clk);
      bus.mode = 1'b1;
      repeat (2) @(negedge clk);
      check_output("mode_valid_drop", bus.valid, 0);
      wait_idle("max_scan");
      check_output("max_result", bus.result, 4'd9);
      check_output("max_index", bus.result_index, 2'd2);
      check_output("max_char", bus.result_char, 8'h39);

      $display("[TB] tie cases");
      @(negedge clk);
      bus.mode = 1'b0;
      wait_idle("mode_back");
      apply_stimulus(4'b0001, 4'd4, 4);
      apply_stimulus(4'b0010, 4'd2, 4);
      apply_stimulus(4'b0100, 4'd2, 4);
      apply_stimulus(4'b1000, 4'd8, 4);
      wait_idle("tie_min");
      check_output("tie_min_result", bus.result, 4'd2);
      check_output("tie_min_index", bus.result_index, 2'd1);
      apply_stimulus(4'b1111, 4'd15, 4);
      @(negedge clk);
      bus.mode = 1'b1;
      wait_idle("tie_max");
      check_output("tie_max_result", bus.result, 4'd15);
      check_output("tie_max_index", bus.result_index, 2'd0);
      check_output("tie_max_char", bus.result_char, 8'h46);

      $display("[TB] load during a running scan");
      @(negedge clk);
      bus.mode = 1'b0;
      repeat (2) @(negedge clk);
      bus.holder   = 4'd1;
      bus.load     = 4'b0100;
      busy_dropped = 1'b0;
      n = 0;
      while (bus.valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 4) bus.load = '0;
         if (bus.valid !== 1'b1 && bus.busy !== 1'b1) busy_dropped = 1'b1;
      end
      check_output("restart_completed", n < 40, 1);
      check_output("restart_busy_held", busy_dropped, 0);
      check_output("restart_result", bus.result, 4'd1);
      check_output("restart_index", bus.result_index, 2'd2);

      $display("[TB] held load level");
      @(negedge clk);
      bus.holder = 4'd6;
      bus.load   = 4'b0001;
      starts     = 0;
      prev_busy  = bus.busy;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 4) bus.holder = 4'd12;
         if (c == 19) bus.load = '0;
         if (bus.busy === 1'b1 && prev_busy !== 1'b1) starts++;
         prev_busy = bus.busy;
      end
      check_output("held_one_rescan", starts, 1);
      check_output("held_value0", bus.values[3:0], 4'd6);
      wait_idle("held");
      apply_stimulus(4'b1010, 4'd0, 4);
      wait_idle("dual_load");
      check_output("dual_values", bus.values, 16'h0106);
      check_output("dual_result", bus.result, 4'd0);
      check_output("dual_index", bus.result_index, 2'd1);

      $display("[TB] reset during a scan");
      apply_stimulus(4'b0100, 4'd5, 4);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check_output("midrst_values", bus.values, 16'h0000);
      check_output("midrst_result", bus.result, 0);
      check_output("midrst_index", bus.result_index, 0);
      check_output("midrst_char", bus.result_char, 8'h30);
      check_output("midrst_valid", bus.valid, 0);
      check_output("midrst_busy", bus.busy, 0);
      @(negedge clk);
      reset = 1'b0;
      busy_seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.busy === 1'b1 || bus.valid === 1'b1) busy_seen++;
      end
      check_output("midrst_no_rescan", busy_seen, 0);

      $display("[TB] randomized loads and mode changes");
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.mode = ~bus.mode;
         end else begin
            apply_stimulus(N'($urandom_range(1, (1 << N) - 1)), W'($urandom),
                           $urandom_range(3, 8));
         end
         repeat ($urandom_range(0, 10)) @(negedge clk);
      end
      wait_idle("random_end");

      $display("[TB] wide instance N=8 W=8");
      vals8 = '{8'hC0, 8'hD1, 8'hAB, 8'hFF, 8'hEE, 8'hBC, 8'hAC, 8'hCD};
      for (int k = 0; k < N8; k++) begin
         @(negedge clk);
         bus8.holder = vals8[k];
         bus8.load   = N8'(1) << k;
         repeat (4) @(negedge clk);
         bus8.load = '0;
      end
      n = 0;
      while (!(bus8.valid === 1'b1 && bus8.busy === 1'b0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_output("wide_min_done", n < 60, 1);
      best8 = 0;
      for (int k = 0; k < N8; k++) begin
         exp8[k*W8 +: W8] = vals8[k];
         if (vals8[k] < vals8[best8]) best8 = k;
      end
      check_output("wide_values", bus8.values, exp8);
      check_output("wide_min_model", bus8.result, vals8[best8]);
      check_output("wide_min_result", bus8.result, 8'hAB);
      check_output("wide_min_index", bus8.result_index, 3'd2);
      check_output("wide_min_char", bus8.result_char, 8'h42);
      @(negedge clk);
      bus8.mode = 1'b1;
      repeat (3) @(negedge clk);
      n = 0;
      while (!(bus8.valid === 1'b1 && bus8.busy === 1'b0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_output("wide_max_done", n < 60, 1);
      check_output("wide_max_result", bus8.result, 8'hFF);
      check_output("wide_max_index", bus8.result_index, 3'd3);
      check_output("wide_max_char", bus8.result_char, 8'h46);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
